// File: rtl/bool_fn_pkg.sv
// Shared definitions for the boolean_function_* family of glue cells.
package bool_fn_pkg;

   // Default function for boolean_function_2_a: d = a&b | ~b&c
   localparam logic [7:0] BF2A_DEFAULT_TT = 8'hE2;

   // Width of the truth-table index {a,b,c}
   localparam int unsigned TT_IDX_W = 3;

   // Look up one output bit of an 8-entry truth table; bit i is f(idx == i).
   function automatic logic tt_lookup(input logic [7:0] tt,
                                      input logic [TT_IDX_W-1:0] idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/bool_lut3.sv
// Purely combinational 3-input lookup: y = tt[{a,b,c}].
module bool_lut3
   import bool_fn_pkg::*;
(
   input  logic [7:0] tt,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   output logic       y
);

   logic [TT_IDX_W-1:0] idx;

   // a is the MSB of the index, c the LSB
   always_comb begin
      idx = {a, b, c};
      y   = tt_lookup(tt, idx);
   end

endmodule

// File: rtl/boolean_function_2_a.sv
// Registered three-input Boolean function with a combinational side output.
module boolean_function_2_a
   import bool_fn_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = BF2A_DEFAULT_TT,
   parameter logic       RESET_VALUE = 1'b0
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic d,
   output logic d_comb
);

   logic f;

   bool_lut3 u_lut (
      .tt (TRUTH_TABLE),
      .a  (a),
      .b  (b),
      .c  (c),
      .y  (f)
   );

   assign d_comb = f;

   // Capture f every cycle; reset forces RESET_VALUE immediately and wins over a capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d <= RESET_VALUE;
      end else begin
         d <= f;
      end
   end

endmodule

// File: tb/tb_boolean_function_2_a.sv
// Self-checking bench: default table, XOR override and RESET_VALUE=1 override.
module tb_boolean_function_2_a;

   logic clk;
   logic rst_n;
   logic rst_rv_n;
   logic a, b, c;
   logic d, d_comb;
   logic d_x, d_comb_x;
   logic d_rv, d_comb_rv;

   int checks = 0;
   int errors = 0;

   logic exp_q[$];
   logic exp_x_q[$];

   boolean_function_2_a dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .d_comb (d_comb)
   );

   boolean_function_2_a #(.TRUTH_TABLE(8'h96)) dut_xor (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d_x),
      .d_comb (d_comb_x)
   );

   boolean_function_2_a #(.RESET_VALUE(1'b1)) dut_rv (
      .clk    (clk),
      .rst_n  (rst_rv_n),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d_rv),
      .d_comb (d_comb_rv)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference models written as sum of products / parity
   function automatic logic refDefault(input logic [2:0] idx);
      return (idx[2] & idx[1]) | (~idx[1] & idx[0]);
   endfunction

   function automatic logic refXor(input logic [2:0] idx);
      return idx[2] ^ idx[1] ^ idx[0];
   endfunction

   task automatic checkOutput(input string tag, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
      end
   endtask

   // Drive one index at the falling edge, check comb outputs, then check registered ones
   task automatic applyStimulus(input logic [2:0] idx);
      logic ed, ex;
      @(negedge clk);
      {a, b, c} = idx;
      #1;
      checkOutput($sformatf("d_comb[%0d]", idx), d_comb, refDefault(idx));
      checkOutput($sformatf("d_comb_xor[%0d]", idx), d_comb_x, refXor(idx));
      exp_q.push_back(refDefault(idx));
      exp_x_q.push_back(refXor(idx));
      @(posedge clk);
      #1;
      ed = exp_q.pop_front();
      ex = exp_x_q.pop_front();
      checkOutput($sformatf("d[%0d]", idx), d, ed);
      checkOutput($sformatf("d_xor[%0d]", idx), d_x, ex);
   endtask

   initial begin
      rst_n    = 1'b1;
      rst_rv_n = 1'b1;
      {a, b, c} = 3'b111;
      #2;
      rst_n    = 1'b0;
      rst_rv_n = 1'b0;
      #1;
      checkOutput("reset_d", d, 1'b0);
      checkOutput("reset_d_comb", d_comb, 1'b1);
      checkOutput("reset_rv_d", d_rv, 1'b1);

      // Reset held across several clock edges
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("reset_hold_d", d, 1'b0);
         checkOutput("reset_hold_d_xor", d_x, 1'b0);
         checkOutput("reset_hold_d_comb", d_comb, 1'b1);
      end

      // Release: first edge loads f(111) = 1
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("release_pre_edge", d, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("release_d", d, 1'b1);
      checkOutput("release_d_xor", d_x, 1'b1);

      // Exhaustive binary-count sweep, both tables
      for (int i = 0; i < 8; i++) applyStimulus(3'(i));
      for (int i = 7; i >= 0; i--) applyStimulus(3'(i));

      // Asynchronous reset between edges
      applyStimulus(3'b110);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_d", d, 1'b0);
      @(negedge clk);
      checkOutput("async_reset_hold_neg", d, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("async_reset_hold_pos", d, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("async_release_pre_edge", d, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("async_release_d", d, 1'b1);

      // Mid-cycle glitch 101 -> 100 -> 101
      applyStimulus(3'b101);
      @(negedge clk);
      #1;
      checkOutput("glitch_comb_1", d_comb, 1'b1);
      {a, b, c} = 3'b100;
      #1;
      checkOutput("glitch_comb_0", d_comb, 1'b0);
      checkOutput("glitch_d_mid", d, 1'b1);
      {a, b, c} = 3'b101;
      #1;
      checkOutput("glitch_comb_back", d_comb, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("glitch_d_edge", d, 1'b1);

      // RESET_VALUE=1 instance has been held in reset throughout
      {a, b, c} = 3'b000;
      #1;
      checkOutput("rv_hold_d", d_rv, 1'b1);
      checkOutput("rv_hold_d_comb", d_comb_rv, 1'b0);
      @(negedge clk);
      rst_rv_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rv_release_d", d_rv, 1'b0);
      #2;
      rst_rv_n = 1'b0;
      #1;
      checkOutput("rv_async_d", d_rv, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("rv_async_hold_d", d_rv, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
